// File: rtl/neuron_scheduler.sv
// rtl/neuron_scheduler.sv - time-multiplexes one shared neuron datapath across N_NEURONS virtual neurons
//
// Holds an 8-bit membrane state per virtual neuron. Each timestep walks indices
// 0..N_NEURONS-1 in order. For each index it fetches the weight sum over a
// req/valid handshake, presents state and weight sum to the shared
// (registered) neuron, writes the result back, and emits a spike event when the
// neuron fires. Spike events use valid/ready backpressure.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a timestep (sampled only in IDLE)
//   clr_states        zero all stored states (IDLE only, start has priority)
//   busy, done        timestep in progress / one-cycle end-of-timestep pulse
//   ws_req, ws_idx    weight-sum request and the index being requested
//   ws_valid, ws_data weight-sum response
//   nrn_weight_sum,   operands to the shared neuron, non-zero only in ISSUE
//   nrn_state_in
//   nrn_state_out,    9-bit neuron result and its spike flag, valid in RESULT
//   nrn_spike
//   spk_valid,        spike event (index of the neuron that fired)
//   spk_idx,
//   spk_ready
//   spk_count         spikes in the current or last timestep

module neuron_scheduler #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr_states,
  output logic             busy,
  output logic             done,
  output logic             ws_req,
  output logic [IDX_W-1:0] ws_idx,
  input  logic             ws_valid,
  input  logic [7:0]       ws_data,
  output logic [7:0]       nrn_weight_sum,
  output logic [7:0]       nrn_state_in,
  input  logic [8:0]       nrn_state_out,
  input  logic             nrn_spike,
  output logic             spk_valid,
  output logic [IDX_W-1:0] spk_idx,
  input  logic             spk_ready,
  output logic [IDX_W:0]   spk_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RESULT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       state_mem [N_NEURONS];

  logic             fire;
  logic             advance;
  logic [IDX_W-1:0] idx_next;

  // A conforming neuron drives nrn_spike equal to nrn_state_out[8]; either one
  // marks a sum of 256 or more.
  assign fire = nrn_spike | nrn_state_out[8];

  // Leaving RESULT without a spike, or EMIT on the handshake, moves on to the
  // next index (or finishes the timestep). Not a state of its own.
  assign advance  = ((state == S_RESULT) && !fire) ||
                    ((state == S_EMIT) && spk_ready);
  assign idx_next = idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ws_req         <= 1'b0;
      ws_idx         <= '0;
      nrn_weight_sum <= 8'd0;
      nrn_state_in   <= 8'd0;
      spk_valid      <= 1'b0;
      spk_idx        <= '0;
      spk_count      <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_mem[i] <= 8'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            ws_idx    <= '0;
            ws_req    <= 1'b1;
            busy      <= 1'b1;
            spk_count <= '0;
            state     <= S_FETCH;
          end else if (clr_states) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              state_mem[i] <= 8'd0;
            end
          end
        end

        S_FETCH: begin
          // nrn_weight_sum doubles as the latched weight-sum register: it is
          // loaded here and presented to the neuron throughout ISSUE.
          if (ws_valid) begin
            ws_req         <= 1'b0;
            nrn_weight_sum <= ws_data;
            nrn_state_in   <= state_mem[idx];
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The neuron captures its operands on this edge.
          nrn_weight_sum <= 8'd0;
          nrn_state_in   <= 8'd0;
          state          <= S_RESULT;
        end

        S_RESULT: begin
          // A firing neuron resets its membrane.
          state_mem[idx] <= fire ? 8'd0 : nrn_state_out[7:0];
          if (fire) begin
            spk_valid <= 1'b1;
            spk_idx   <= idx;
            spk_count <= spk_count + (IDX_W+1)'(1);
            state     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (spk_ready) begin
            spk_valid <= 1'b0;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (advance) begin
        if (idx == LAST_IDX) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          idx    <= idx_next;
          ws_idx <= idx_next;
          ws_req <= 1'b1;
          state  <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb/tb_neuron_scheduler.sv - scoreboard bench for neuron_scheduler

module tb_neuron_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clr_states;
  logic       busy;
  logic       done;
  logic       ws_req;
  logic [3:0] ws_idx;
  logic       ws_valid;
  logic [7:0] ws_data;
  logic [7:0] nrn_weight_sum;
  logic [7:0] nrn_state_in;
  logic [8:0] nrn_state_out;
  logic       nrn_spike;
  logic       spk_valid;
  logic [3:0] spk_idx;
  logic       spk_ready;
  logic [4:0] spk_count;

  neuron_scheduler #(.N_NEURONS(16), .IDX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .clr_states     (clr_states),
    .busy           (busy),
    .done           (done),
    .ws_req         (ws_req),
    .ws_idx         (ws_idx),
    .ws_valid       (ws_valid),
    .ws_data        (ws_data),
    .nrn_weight_sum (nrn_weight_sum),
    .nrn_state_in   (nrn_state_in),
    .nrn_state_out  (nrn_state_out),
    .nrn_spike      (nrn_spike),
    .spk_valid      (spk_valid),
    .spk_idx        (spk_idx),
    .spk_ready      (spk_ready),
    .spk_count      (spk_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_seen = 0;
  int req7 = 0;

  int exp_spk[$];
  int exp_cnt_q[$];
  int exp_cyc_q[$];
  int issued_state [16];
  int issued_wsum [16];

  logic [7:0] ws_tab [16];
  logic [8:0] nrn_sum = 9'd0;
  logic [3:0] hold_cfg = 4'd0;
  logic [3:0] hold_left = 4'd0;
  logic [3:0] stall_cfg = 4'd0;
  logic [3:0] stall_left = 4'd0;
  logic [3:0] stall_idx = 4'd7;

  // Shared neuron: registered 8b+8b adder.
  always @(posedge clk) nrn_sum <= {1'b0, nrn_state_in} + {1'b0, nrn_weight_sum};
  assign nrn_state_out = nrn_sum;
  assign nrn_spike     = nrn_sum[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Weight-sum source with optional stall on one index; spike sink with
  // a configurable number of not-ready cycles per event.
  always @(posedge clk) begin
    if (!spk_valid) hold_left <= hold_cfg;
    else if (hold_left != 0) hold_left <= hold_left - 4'd1;
    if (!(ws_req && ws_idx == stall_idx)) stall_left <= stall_cfg;
    else if (stall_left != 0) stall_left <= stall_left - 4'd1;
  end
  assign spk_ready = (hold_left == 4'd0);
  assign ws_valid  = !(ws_req && ws_idx == stall_idx && stall_left != 0);
  assign ws_data   = ws_tab[ws_idx];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_ws(input int v);
    for (int i = 0; i < 16; i++) ws_tab[i] = 8'(v);
  endtask

  // Monitor: pops expected spikes/done events whenever the DUT presents them.
  initial begin
    bit       issue_pend = 1'b0;
    bit       prev_valid = 1'b0;
    int       issue_idx = 0;
    int       prev_idx = 0;
    int       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        issue_pend = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (issue_pend) begin
          issued_state[issue_idx] = int'(nrn_state_in);
          issued_wsum[issue_idx]  = int'(nrn_weight_sum);
        end
        issue_pend = ws_req && ws_valid;
        issue_idx  = int'(ws_idx);
        if (ws_req && ws_idx == 4'd7) req7++;

        if (prev_valid) begin
          chk("spk_valid_held", int'(spk_valid), 1);
          chk("spk_idx_held", int'(spk_idx), prev_idx);
        end
        if (spk_valid && spk_ready) begin
          if (exp_spk.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_spike actual idx %0d required none", spk_idx);
          end else begin
            e = exp_spk.pop_front();
            chk("spk_idx", int'(spk_idx), e);
          end
        end
        prev_valid = spk_valid && !spk_ready;
        prev_idx   = int'(spk_idx);

        if (done) begin
          done_seen++;
          if (exp_cnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual 1 required 0 at cyc %0d", cyc);
          end else begin
            chk("spk_count_at_done", int'(spk_count), exp_cnt_q.pop_front());
            chk("done_cycle", cyc - start_cyc + 1, exp_cyc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run_step(input int exp_cnt, input int exp_cyc, input bit mid_start);
    int seen0;
    bit got;
    exp_cnt_q.push_back(exp_cnt);
    exp_cyc_q.push_back(exp_cyc);
    req7  = 0;
    seen0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_after_start", int'(busy), 1);
    chk("ws_req_after_start", int'(ws_req), 1);
    if (mid_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done_seen != seen0) got = 1'b1;
    end
    chk("done_arrived", int'(got), 1);
    chk("spk_queue_drained", exp_spk.size(), 0);
  endtask

  initial begin
    bit got;
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
    got = 1'b0;
  end

  initial begin
    bit got;
    rst = 1'b1;
    start = 1'b0;
    clr_states = 1'b0;
    set_ws(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ws_req", int'(ws_req), 0);
    chk("rst_ws_idx", int'(ws_idx), 0);
    chk("rst_nrn_ws", int'(nrn_weight_sum), 0);
    chk("rst_nrn_si", int'(nrn_state_in), 0);
    chk("rst_spk_valid", int'(spk_valid), 0);
    chk("rst_spk_idx", int'(spk_idx), 0);
    chk("rst_spk_count", int'(spk_count), 0);
    #1 rst = 1'b0;

    // Idle timestep: all zero weights.
    run_step(0, 49, 1'b0);

    // Accumulate idx 3 by 0x30 per timestep; fires on the sixth.
    set_ws(0);
    ws_tab[3] = 8'h30;
    for (int t = 1; t <= 5; t++) run_step(0, 49, 1'b0);
    chk("state3_t5", issued_state[3], 192);
    exp_spk.push_back(3);
    run_step(1, 50, 1'b0);
    chk("state3_t6", issued_state[3], 240);
    chk("wsum3_t6", issued_wsum[3], 48);
    run_step(0, 49, 1'b0);
    chk("state3_after_fire", issued_state[3], 0);

    // Boundary: 200+55=255 no spike, then 255+1=256 spikes.
    set_ws(0);
    ws_tab[0] = 8'd200;
    run_step(0, 49, 1'b0);
    ws_tab[0] = 8'd55;
    run_step(0, 49, 1'b0);
    chk("state0_200", issued_state[0], 200);
    ws_tab[0] = 8'd1;
    exp_spk.push_back(0);
    run_step(1, 50, 1'b0);
    chk("state0_255", issued_state[0], 255);
    chk("wsum0_1", issued_wsum[0], 1);

    // clr_states in IDLE wipes idx 3 (48).
    @(negedge clk);
    clr_states = 1'b1;
    @(posedge clk);
    #1 clr_states = 1'b0;
    set_ws(0);
    run_step(0, 49, 1'b0);
    chk("state3_cleared", issued_state[3], 0);

    // Backpressure: every neuron fires, 5 not-ready cycles per event.
    set_ws(128);
    run_step(0, 49, 1'b0);
    hold_cfg = 4'd5;
    for (int i = 0; i < 16; i++) exp_spk.push_back(i);
    run_step(16, 145, 1'b0);
    chk("state15_128", issued_state[15], 128);
    repeat (3) @(negedge clk);
    chk("spk_count_holds", int'(spk_count), 16);
    hold_cfg = 4'd0;

    // FETCH stall on idx 7 for 4 cycles.
    set_ws(0);
    ws_tab[7] = 8'h40;
    stall_cfg = 4'd4;
    run_step(0, 53, 1'b0);
    chk("ws_req_idx7_cycles", req7, 5);
    stall_cfg = 4'd0;
    run_step(0, 49, 1'b0);
    chk("state7_after_stall", issued_state[7], 64);

    // Reset during EMIT: idx 7 at 128 + 200 fires.
    ws_tab[7] = 8'd200;
    hold_cfg = 4'd5;
    exp_spk.push_back(7);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (spk_valid) got = 1'b1;
    end
    chk("spk_before_rst", int'(got), 1);
    chk("spk_idx_before_rst", int'(spk_idx), 7);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_spk_valid", int'(spk_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_spk_count", int'(spk_count), 0);
    chk("midrst_ws_req", int'(ws_req), 0);
    chk("midrst_done", int'(done), 0);
    #1 rst = 1'b0;
    exp_spk.delete();
    hold_cfg = 4'd0;
    repeat (8) @(negedge clk);

    // States zeroed by reset; start during busy is ignored.
    set_ws(0);
    run_step(0, 49, 1'b1);
    chk("state7_after_rst", issued_state[7], 0);
    repeat (3) @(negedge clk);
    chk("idle_after_done", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_scheduler.md
# neuron_scheduler

Time-multiplexes one shared `neuron` datapath across `N_NEURONS` virtual neurons. Holds each neuron's 8-bit membrane state in an internal register array. On each timestep `start` it walks every index in order:

- fetches that index's weight sum through a request/valid handshake;
- issues state and weight sum to the shared neuron;
- writes the result back;
- emits a spike event with backpressure.

The block sits between the synapse/weight-accumulation stage and the spike output fabric.

## Interface
- `N_NEURONS`, default 16, number of virtual neurons (≥2).
- `IDX_W`, default 4, index width, ≥ clog2(`N_NEURONS`).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin one timestep; sampled only in IDLE.
- `clr_states`  in  1  zero all stored states; honoured only in IDLE when `start`=0.
- `busy`  out  1  timestep in progress.
- `done`  out  1  one-cycle pulse at end of timestep.
- `ws_req`  out  1  weight-sum request.
- `ws_idx`  out  `IDX_W`  neuron index being requested.
- `ws_valid`  in  1  weight-sum data valid.
- `ws_data`  in  8  weight sum for `ws_idx`.
- `nrn_weight_sum`  out  8  to shared neuron `weight_sum`.
- `nrn_state_in`  out  8  to shared neuron `state_in`.
- `nrn_state_out`  in  9  from shared neuron `state_out`.
- `nrn_spike`  in  1  from shared neuron `spike_out`, equal to `nrn_state_out[8]`.
- `spk_valid`  out  1  spike event valid.
- `spk_idx`  out  `IDX_W`  index of the neuron that spiked.
- `spk_ready`  in  1  spike consumer ready.
- `spk_count`  out  `IDX_W`+1  spikes in the current or last timestep.

## Operation
- **State storage:** `state_mem[N_NEURONS]` × 8 bits. Cleared by `rst` or by `clr_states`.
- **IDLE**
  - Outputs idle.
  - `start`=1 → `idx`=0, `spk_count`=0, go to FETCH.
  - `start` and `clr_states` together: `start` wins and `clr_states` is ignored.
- **FETCH**
  - Drive `ws_req`=1, `ws_idx`=`idx`.
  - When `ws_valid`=1 in the same cycle: latch `ws_data` into `wsum_r`, go to ISSUE.
  - Otherwise stay in FETCH.
- **ISSUE**
  - Drive `nrn_weight_sum`=`wsum_r`, `nrn_state_in`=`state_mem[idx]`.
  - The neuron registers these on the closing edge. Go to RESULT.
- **RESULT** (`nrn_state_out` is valid in this cycle)
  - Write back `state_mem[idx]` = `nrn_spike` ? 0 : `nrn_state_out[7:0]`.
  - If `nrn_spike`: set `spk_valid`=1, `spk_idx`=`idx`, increment `spk_count`, go to EMIT.
  - If no spike: go to ADVANCE.
- **EMIT**
  - Hold `spk_valid`/`spk_idx` stable until `spk_valid`&&`spk_ready`.
  - On that handshake: clear `spk_valid`, go to ADVANCE.
- **ADVANCE** (a decision taken on the exit edge of RESULT or EMIT, not a separate state)
  - `idx`==`N_NEURONS`-1 → DONE.
  - Otherwise `idx`+1 → FETCH.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
  - `spk_count` holds until the next `start`.
- **Arithmetic:** 8b + 8b → 9b in the neuron; no wrap is possible (max 510). Spike iff bit 8 is set, i.e. sum ≥ 256.
- **Output defaults:**
  - `nrn_weight_sum`/`nrn_state_in` are 0 in every state except ISSUE.
  - `ws_req`=0 outside FETCH; `ws_idx` holds `idx`.
- **Ignored inputs:**
  - `start` is ignored while `busy`=1.
  - `ws_valid` is ignored outside FETCH.

## Timing
- **Reset values:** `busy`=0, `done`=0, `ws_req`=0, `ws_idx`=0, `nrn_*`=0, `spk_valid`=0, `spk_idx`=0, `spk_count`=0. State goes to IDLE; all `state_mem` = 0.
- **`busy`:** 1 in FETCH/ISSUE/RESULT/EMIT, 0 in IDLE and DONE.
- **Per-neuron latency:** 3 cycles (FETCH, ISSUE, RESULT) with `ws_valid` already high and no spike.
  - Each extra FETCH wait cycle adds 1.
  - A spike adds ≥1 EMIT cycle.
- **Full timestep, no stalls, no spikes:** `start` sampled at edge 0; neuron k occupies cycles 3k+1..3k+3; `done` is high in cycle 3·`N_NEURONS`+1 (cycle 49 for N=16).
- **Earliest next timestep:** `start` may be accepted in the IDLE cycle right after DONE.
- **`clr_states`:** takes effect on the edge it is sampled.
- **Reset mid-timestep:** `rst` takes priority in any state.
  - Returns to IDLE next cycle with all reset values, including any pending spike.
  - No `done` pulse is issued.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles → all outputs 0. Then `start` with `ws_valid` tied high and `ws_data`=0 → `done` at cycle 49, `spk_count`=0, no `spk_valid`.
- **Accumulate then fire:** `ws_data`=0x30 for idx 3 (0 for the others), 6 timesteps → no spike in timesteps 1–5 (state 240 after t5). Timestep 6: sum 288 → `spk_valid` with `spk_idx`=3, `spk_count`=1, stored state 0.
- **Boundary:** preload idx 0 to 200 with `ws_data`=55 (sum 255) → no spike, state 255. Next timestep `ws_data`=1 → sum 256 → spike.
- **Backpressure:** all neurons spike, `spk_ready` low 5 cycles per event → each `spk_valid`/`spk_idx` held stable, indices 0..15 in order, `spk_count`=16, `done` delayed accordingly.
- **FETCH stall:** `ws_valid` low 4 cycles for idx 7 → `ws_req` and `ws_idx`=7 held; result identical to the no-stall case.
- **Reset mid-operation / ignored inputs:** `rst` during EMIT → `spk_valid` drops, IDLE, states 0, no `done`. `start` during `busy` → ignored. `clr_states` in IDLE → all states 0.
